// File: rtl/rotate_seq_pkg.sv
// Shared types for the frame-rate vertex rotation sequencer:
// state encoding, direction codes and the saturating negate.
package rotate_seq_pkg;

   localparam int COORD_W = 10;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_WRITE,
      S_DONE
   } state_t;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_HOLD = 2'b00;
   localparam dir_t DIR_FWD  = 2'b01;
   localparam dir_t DIR_REV  = 2'b10;

   localparam coord_t COORD_MIN = {1'b1, {(COORD_W-1){1'b0}}};
   localparam coord_t COORD_MAX = {1'b0, {(COORD_W-1){1'b1}}};

   // Two's-complement negate; the most negative code has no mirror.
   function automatic coord_t negsat(input coord_t v);
      return (v == COORD_MIN) ? COORD_MAX : -v;
   endfunction

endpackage

// File: rtl/rotate_seq_if.sv
// Vertex RAM and external rotator bus seen by the sequencer.
// master = sequencer side, slave = RAM / rotator side.
interface rotate_seq_if #(
   parameter int ADDR_W = 4
);
   import rotate_seq_pkg::*;

   logic [ADDR_W-1:0]    rd_addr_o;
   logic [2*COORD_W-1:0] rd_data_i;
   logic                 wr_en_o;
   logic [ADDR_W-1:0]    wr_addr_o;
   logic [2*COORD_W-1:0] wr_data_o;
   coord_t               rot_x_o;
   coord_t               rot_y_o;
   coord_t               rot_x_i;
   coord_t               rot_y_i;

   modport master (
      output rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
      output rot_x_o, rot_y_o,
      input  rd_data_i, rot_x_i, rot_y_i
   );

   modport slave (
      input  rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
      input  rot_x_o, rot_y_o,
      output rd_data_i, rot_x_i, rot_y_i
   );

endinterface

// File: rtl/rotate_seq.sv
// Per-frame read/rotate/write-back walk over the vertex RAM.
// Reverse sense is built by negating y around the one rotator.
module rotate_seq
   import rotate_seq_pkg::*;
#(
   parameter int N_VERT = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_i,
   input  dir_t                dir_i,
   rotate_seq_if.master        bus,
   output logic                busy_o,
   output logic                done_o,
   output logic                miss_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_VERT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              rev_q, rev_d;
   logic              miss_q, miss_d;
   coord_t            vx_q, vx_d;
   coord_t            vy_q, vy_d;
   coord_t            rd_x, rd_y;
   logic              last;
   logic              wr_en;
   logic              go;

   assign last = (idx_q == LAST);
   assign go   = (dir_i == DIR_FWD) || (dir_i == DIR_REV);
   assign rd_x = bus.rd_data_i[2*COORD_W-1 -: COORD_W];
   assign rd_y = bus.rd_data_i[COORD_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (frame_i) state_d = go ? S_READ : S_DONE;
         S_READ:  state_d = S_LATCH;
         S_LATCH: state_d = S_WRITE;
         S_WRITE: state_d = last ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d     = idx_q;
      rev_d     = rev_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      miss_d    = frame_i && (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE:
            if (frame_i) begin
               rev_d = (dir_i == DIR_REV);
               idx_d = '0;
            end
         S_LATCH: begin
            vx_d = rd_x;
            vy_d = rev_q ? negsat(rd_y) : rd_y;
         end
         S_WRITE:
            if (!last) idx_d = idx_q + 1'b1;
         default: ;
      endcase
      // Addresses are registered so they hold while idle.
      if (state_d == S_READ)  rd_addr_d = idx_d;
      if (state_d == S_WRITE) wr_addr_d = idx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         rev_q     <= 1'b0;
         vx_q      <= '0;
         vy_q      <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         miss_q    <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         rev_q     <= rev_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         miss_q    <= miss_d;
      end
   end

   // Strobes are masked by rst so an abort never lands a write.
   assign wr_en = (state_q == S_WRITE) && !rst;

   always_comb begin
      bus.rd_addr_o = rd_addr_q;
      bus.wr_addr_o = wr_addr_q;
      bus.wr_en_o   = wr_en;
      bus.rot_x_o   = vx_q;
      bus.rot_y_o   = vy_q;
      bus.wr_data_o = '0;
      if (wr_en)
         bus.wr_data_o = {bus.rot_x_i,
                          rev_q ? negsat(bus.rot_y_i) : bus.rot_y_i};
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE) && !rst;
      miss_o = miss_q;
   end

endmodule

// File: tb/tb_rotate_seq.sv
// Directed + randomized bench for rotate_seq with a RAM and
// fixed-angle rotator model (SIN=89, COS=1020, floor >>10).
module tb_rotate_seq;
   import rotate_seq_pkg::*;

   localparam int AW = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       f1 = 1'b0, f16 = 1'b0;
   logic [1:0] d1 = 2'b00, d16 = 2'b00;
   logic       busy1, done1, miss1;
   logic       busy16, done16, miss16;

   logic        ld1 = 1'b0, ld16 = 1'b0;
   logic [3:0]  lda = '0;
   logic [19:0] ldd = '0;
   logic [19:0] ram1 [16];
   logic [19:0] ram16 [16];
   logic [19:0] mdl [16];

   int n_chk = 0;
   int n_fail = 0;

   rotate_seq_if #(.ADDR_W(AW)) b1 ();
   rotate_seq_if #(.ADDR_W(AW)) b16 ();

   rotate_seq #(.N_VERT(1), .ADDR_W(AW)) dut1 (
      .clk(clk), .rst(rst), .frame_i(f1), .dir_i(d1),
      .bus(b1.master), .busy_o(busy1), .done_o(done1),
      .miss_o(miss1)
   );

   rotate_seq #(.N_VERT(16), .ADDR_W(AW)) dut16 (
      .clk(clk), .rst(rst), .frame_i(f16), .dir_i(d16),
      .bus(b16.master), .busy_o(busy16), .done_o(done16),
      .miss_o(miss16)
   );

   always #5 clk = ~clk;

   // Native rotator: x' = xC + yS, y' = yC - xS, floored, 10-bit wrap
   function automatic logic [19:0] rot(input logic [19:0] xy);
      int x, y, xo, yo;
      x  = int'($signed(xy[19:10]));
      y  = int'($signed(xy[9:0]));
      xo = (x * 1020 + y * 89) >>> 10;
      yo = (y * 1020 - x * 89) >>> 10;
      return {xo[9:0], yo[9:0]};
   endfunction

   function automatic logic [9:0] nsat(input logic [9:0] v);
      int iv;
      iv = int'($signed(v));
      iv = (iv == -512) ? 511 : -iv;
      return iv[9:0];
   endfunction

   function automatic logic [19:0] step(input logic [19:0] w,
                                        input bit rev);
      logic [19:0] r;
      if (!rev) return rot(w);
      r = rot({w[19:10], nsat(w[9:0])});
      return {r[19:10], nsat(r[9:0])};
   endfunction

   always_comb begin
      {b1.rot_x_i, b1.rot_y_i}   = rot({b1.rot_x_o, b1.rot_y_o});
      {b16.rot_x_i, b16.rot_y_i} = rot({b16.rot_x_o, b16.rot_y_o});
   end

   always @(posedge clk) begin
      if (ld1) ram1[lda] <= ldd;
      else if (b1.wr_en_o) ram1[b1.wr_addr_o] <= b1.wr_data_o;
      if (ld16) ram16[lda] <= ldd;
      else if (b16.wr_en_o) ram16[b16.wr_addr_o] <= b16.wr_data_o;
      b1.rd_data_i  <= ram1[b1.rd_addr_o];
      b16.rd_data_i <= ram16[b16.rd_addr_o];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input bit big, input int a,
                       input logic [19:0] d);
      lda = a[3:0];
      ldd = d;
      ld1 = !big;
      ld16 = big;
      tick();
      ld1 = 1'b0;
      ld16 = 1'b0;
   endtask

   task automatic cmp_ram16(input string tag);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s[%0d]", tag, i), ram16[i], mdl[i]);
   endtask

   // One full 16-vertex pass; optional extra frame at cycle miss_at.
   task automatic pass16(input logic [1:0] dir, input int miss_at);
      int nb;
      bit ew;
      nb = 0;
      f16 = 1'b1;
      d16 = dir;
      tick();
      for (int c = 1; c <= 50; c++) begin
         f16 = (c == miss_at);
         if (c == miss_at) d16 = ~dir;
         ew = (c >= 3) && (c <= 48) && (c % 3 == 0);
         chk($sformatf("p16 wr_en c%0d", c), b16.wr_en_o, ew);
         if (ew)
            chk($sformatf("p16 wr_addr c%0d", c), b16.wr_addr_o,
                c / 3 - 1);
         if ((c % 3 == 1) && (c <= 46))
            chk($sformatf("p16 rd_addr c%0d", c), b16.rd_addr_o,
                (c - 1) / 3);
         chk($sformatf("p16 done c%0d", c), done16, c == 49);
         if (miss_at > 0)
            chk($sformatf("p16 miss c%0d", c), miss16,
                c == miss_at + 1);
         if (busy16) nb++;
         tick();
      end
      f16 = 1'b0;
      chk("p16 busy span", nb, 49);
   endtask

   initial begin
      logic [19:0] w;
      repeat (2) tick();
      chk("rst busy", busy16, 0);
      chk("rst done", done16, 0);
      chk("rst miss", miss16, 0);
      chk("rst wr_en", b16.wr_en_o, 0);
      chk("rst rd_addr", b16.rd_addr_o, 0);
      chk("rst wr_addr", b16.wr_addr_o, 0);
      chk("rst wr_data", b16.wr_data_o, 0);
      chk("rst rot", {b1.rot_x_o, b1.rot_y_o}, 0);
      rst = 1'b0;
      tick();

      // N=1 forward, (100,0) -> (99,-9)
      load(0, 0, {10'd100, 10'd0});
      f1 = 1'b1; d1 = DIR_FWD; tick(); f1 = 1'b0;
      chk("f1 busy c1", busy1, 1);
      chk("f1 rd_addr c1", b1.rd_addr_o, 0);
      tick();
      chk("f1 wr_en c2", b1.wr_en_o, 0);
      tick();
      chk("f1 wr_en c3", b1.wr_en_o, 1);
      chk("f1 wr_data c3", b1.wr_data_o, {10'd99, 10'h3F7});
      tick();
      chk("f1 done c4", done1, 1);
      chk("f1 wr_en c4", b1.wr_en_o, 0);
      tick();
      chk("f1 done c5", done1, 0);
      chk("f1 busy c5", busy1, 0);
      chk("f1 ram", ram1[0], {10'd99, 10'h3F7});

      // N=1 reverse, (100,0) -> (99,9)
      load(0, 0, {10'd100, 10'd0});
      f1 = 1'b1; d1 = DIR_REV; tick(); f1 = 1'b0;
      repeat (2) tick();
      chk("r1 wr_data c3", b1.wr_data_o, {10'd99, 10'd9});
      repeat (2) tick();
      chk("r1 ram", ram1[0], {10'd99, 10'd9});

      // Reverse with y=-512 saturates to +511 at the rotator
      w = {10'd37, 10'h200};
      load(0, 0, w);
      f1 = 1'b1; d1 = DIR_REV; tick(); f1 = 1'b0;
      repeat (2) tick();
      chk("sat rot_x", b1.rot_x_o, 37);
      chk("sat rot_y", b1.rot_y_o, 10'd511);
      chk("sat no X", $isunknown(b1.wr_data_o), 0);
      chk("sat wr_data", b1.wr_data_o, step(w, 1));
      repeat (2) tick();
      chk("sat ram", ram1[0], step(w, 1));

      // N=16 random forward pass
      for (int i = 0; i < 16; i++) begin
         w = 20'($urandom());
         if (i == 5) w[9:0] = 10'h200;
         mdl[i] = w;
         load(1, i, w);
      end
      pass16(DIR_FWD, 0);
      for (int i = 0; i < 16; i++) mdl[i] = step(mdl[i], 0);
      cmp_ram16("fwd ram");

      // Reverse pass with a stray frame at cycle 10
      pass16(DIR_REV, 10);
      for (int i = 0; i < 16; i++) mdl[i] = step(mdl[i], 1);
      cmp_ram16("rev ram");

      // Reset at cycle 5 of a pass aborts it
      f16 = 1'b1; d16 = DIR_FWD; tick(); f16 = 1'b0;
      repeat (2) tick();
      chk("abort wr_en c3", b16.wr_en_o, 1);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("abort wr_en c5", b16.wr_en_o, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("abort busy c6", busy16, 0);
      chk("abort wr_en c6", b16.wr_en_o, 0);
      tick();
      chk("abort wr_en c7", b16.wr_en_o, 0);
      mdl[0] = step(mdl[0], 0);
      cmp_ram16("abort ram");
      pass16(DIR_FWD, 0);
      for (int i = 0; i < 16; i++) mdl[i] = step(mdl[i], 0);
      cmp_ram16("restart ram");

      // Hold code 00: done at cycle 1, no RAM access
      f16 = 1'b1; d16 = DIR_HOLD; tick(); f16 = 1'b0;
      chk("hold done c1", done16, 1);
      chk("hold busy c1", busy16, 1);
      chk("hold wr_en c1", b16.wr_en_o, 0);
      chk("hold rd_addr c1", b16.rd_addr_o, 15);
      tick();
      chk("hold done c2", done16, 0);
      chk("hold busy c2", busy16, 0);
      chk("hold rd_addr c2", b16.rd_addr_o, 15);

      // Hold code 11 with a frame landing in the DONE cycle
      f16 = 1'b1; d16 = 2'b11; tick();
      chk("h11 done c1", done16, 1);
      d16 = DIR_FWD;
      tick();
      f16 = 1'b0;
      chk("h11 miss c2", miss16, 1);
      chk("h11 busy c2", busy16, 0);
      tick();
      chk("h11 miss c3", miss16, 0);
      chk("h11 busy c3", busy16, 0);
      chk("h11 wr_en c3", b16.wr_en_o, 0);
      cmp_ram16("hold ram");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
